shot_arbiter: RTL and testbench

- Shares one submarine board engine between two players.
- Accepts shot requests from both players and grants one at a time, by strict alternation or round-robin.
- Issues the coordinate to the engine and waits out the engine's mandatory 2-cycle post-command gap plus its busy window.
- Returns a per-player hit/miss/done response, keeps per-player hit scores and sequences new-game loading of the board select.

---
 rtl/shot_arb_pkg.sv | 15 +
 rtl/rr_pick2.sv | 14 +
 rtl/shot_arbiter.sv | 177 +++++++++++++++++
 tb/tb_shot_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shot_arb_pkg.sv
// shot_arb_pkg: shared state encoding, response flag positions and coordinate check
package shot_arb_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, GAP, WAIT_BUSY, RESPOND} state_t;
  localparam int RSP_HIT = 0;
  localparam int RSP_DONE = 1;
  localparam int RSP_ERR = 2;
  localparam int RSP_TO = 3;
  localparam int RSP_N = 4;
  localparam int DEF_BOARD_W = 6;
  localparam int DEF_COORD_W = 3;
  localparam int CNT_W = 8;
  function automatic logic coord_ok(input int x, input int y, input int bw);
    return (x < bw) && (y < bw);
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-requester selector, strict turn or round-robin favouring the player not granted last
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       strict,
  input  logic       turn,
  output logic       valid,
  output logic       winner
);
  always_comb begin
    valid = strict ? req[turn] : |req;
    winner = strict ? turn : ((&req) ? ~last : req[1]);
  end
endmodule

// File: rtl/shot_arbiter.sv
// shot_arbiter: shares one board engine between two players, one shot at a time
module shot_arbiter
  import shot_arb_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT = 63,
  parameter int SCORE_W = 6,
  parameter int STRICT_TURN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  input  logic [1:0]         new_game_sel,
  input  logic               p0_req,
  input  logic [COORD_W-1:0] p0_x,
  input  logic [COORD_W-1:0] p0_y,
  output logic               p0_gnt,
  input  logic               p1_req,
  input  logic [COORD_W-1:0] p1_x,
  input  logic [COORD_W-1:0] p1_y,
  output logic               p1_gnt,
  output logic               eng_select_valid,
  output logic [1:0]         eng_init_select,
  output logic               eng_cord_valid,
  output logic [COORD_W-1:0] eng_x,
  output logic [COORD_W-1:0] eng_y,
  input  logic               eng_busy,
  input  logic               eng_hit,
  input  logic               eng_done,
  output logic               rsp_valid,
  output logic               rsp_player,
  output logic               rsp_hit,
  output logic               rsp_done,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic               turn,
  output logic               game_over,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1
);
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RSP_N-1:0]   r_rsp;
  logic               r_player, r_last, r_hit_l, r_done_l, r_to;
  logic               w_valid, w_win, w_ok, w_hit, w_done;
  logic [COORD_W-1:0] w_cx, w_cy;
  logic [SCORE_W-1:0] w_sc0, w_sc1;

  rr_pick2 u_pick (
    .req   ({p1_req, p0_req}),
    .last  (r_last),
    .strict(STRICT_TURN != 0),
    .turn  (turn),
    .valid (w_valid),
    .winner(w_win)
  );

  assign w_cx = w_win ? p1_x : p0_x;
  assign w_cy = w_win ? p1_y : p0_y;
  assign w_ok = coord_ok(int'(w_cx), int'(w_cy), BOARD_W);
  assign w_hit = r_hit_l | eng_hit;
  assign w_done = r_done_l | eng_done;
  assign w_sc0 = (&score0) ? score0 : score0 + SCORE_W'(1);
  assign w_sc1 = (&score1) ? score1 : score1 + SCORE_W'(1);
  assign rsp_hit = r_rsp[RSP_HIT];
  assign rsp_done = r_rsp[RSP_DONE];
  assign rsp_err = r_rsp[RSP_ERR];
  assign rsp_timeout = r_rsp[RSP_TO];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rsp <= '0;
      r_player <= 1'b0;
      r_last <= 1'b0;
      r_hit_l <= 1'b0;
      r_done_l <= 1'b0;
      r_to <= 1'b0;
      p0_gnt <= 1'b0;
      p1_gnt <= 1'b0;
      eng_select_valid <= 1'b0;
      eng_init_select <= '0;
      eng_cord_valid <= 1'b0;
      eng_x <= '0;
      eng_y <= '0;
      rsp_valid <= 1'b0;
      rsp_player <= 1'b0;
      turn <= 1'b0;
      game_over <= 1'b0;
      score0 <= '0;
      score1 <= '0;
    end else begin
      p0_gnt <= 1'b0;
      p1_gnt <= 1'b0;
      eng_select_valid <= 1'b0;
      eng_cord_valid <= 1'b0;
      rsp_valid <= 1'b0;
      r_rsp <= '0;
      // new_game wins from any state and drops an in-flight shot silently
      if (new_game) begin
        r_state <= LOAD;
        eng_select_valid <= 1'b1;
        eng_init_select <= new_game_sel;
        score0 <= '0;
        score1 <= '0;
        game_over <= 1'b0;
        r_hit_l <= 1'b0;
        r_done_l <= 1'b0;
        r_to <= 1'b0;
        r_last <= 1'b0;
        turn <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (!game_over && w_valid) begin
              p0_gnt <= ~w_win;
              p1_gnt <= w_win;
              r_last <= w_win;
              if (!w_ok) begin
                rsp_valid <= 1'b1;
                rsp_player <= w_win;
                r_rsp[RSP_ERR] <= 1'b1;
              end else begin
                r_player <= w_win;
                eng_x <= w_cx;
                eng_y <= w_cy;
                r_state <= ISSUE;
              end
            end
          end
          LOAD: r_state <= IDLE;
          ISSUE: begin
            eng_cord_valid <= 1'b1;
            r_hit_l <= 1'b0;
            r_done_l <= 1'b0;
            r_to <= 1'b0;
            r_cnt <= CNT_W'(GAP_CYCLES);
            r_state <= GAP;
          end
          GAP: begin
            r_hit_l <= w_hit;
            r_done_l <= w_done;
            r_cnt <= (r_cnt <= CNT_W'(1)) ? CNT_W'(TIMEOUT) : r_cnt - CNT_W'(1);
            r_state <= (r_cnt <= CNT_W'(1)) ? WAIT_BUSY : GAP;
          end
          WAIT_BUSY: begin
            r_hit_l <= w_hit;
            r_done_l <= w_done;
            r_cnt <= r_cnt - CNT_W'(1);
            r_to <= eng_busy && (r_cnt <= CNT_W'(1));
            r_state <= (!eng_busy || (r_cnt <= CNT_W'(1))) ? RESPOND : WAIT_BUSY;
          end
          RESPOND: begin
            rsp_valid <= 1'b1;
            rsp_player <= r_player;
            r_state <= IDLE;
            if (r_to) begin
              r_rsp[RSP_TO] <= 1'b1;
              turn <= ~turn;
            end else begin
              r_rsp[RSP_HIT] <= w_hit;
              r_rsp[RSP_DONE] <= w_done;
              if (w_hit && !r_player) score0 <= w_sc0;
              if (w_hit && r_player) score1 <= w_sc1;
              if (w_done) game_over <= 1'b1;
              if (!w_hit && !w_done) turn <= ~turn;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_shot_arbiter.sv
// tb_shot_arbiter: scoreboard bench for shot_arbiter with a scripted engine model
module tb_shot_arbiter;
  localparam int BW = 6, GAP = 2, TMO = 63;
  typedef struct packed {logic p, hit, done, err, to;} exp_t;

  logic clk = 0, rst = 1, new_game = 0;
  logic [1:0] new_game_sel = 0;
  logic p0_req = 0, p1_req = 0, eng_busy = 0, eng_hit = 0, eng_done = 0;
  logic [2:0] p0_x = 0, p0_y = 0, p1_x = 0, p1_y = 0;
  logic p0_gnt, p1_gnt, eng_select_valid, eng_cord_valid, rsp_valid, rsp_player;
  logic rsp_hit, rsp_done, rsp_err, rsp_timeout, turn, game_over;
  logic [1:0] eng_init_select;
  logic [2:0] eng_x, eng_y;
  logic [5:0] score0, score1;

  logic [1:0] u_req = 0;
  logic u_last = 0, u_strict = 0, u_turn = 0, u_valid, u_winner;

  exp_t sb[$];
  exp_t mon_e;
  int n_chk = 0, n_fail = 0, n_rsp = 0, cyc = 0, rsp_cyc = 0;
  logic m_turn = 0, m_go = 0;
  int m_sc0 = 0, m_sc1 = 0;

  shot_arbiter dut (
    .clk(clk), .rst(rst), .new_game(new_game), .new_game_sel(new_game_sel),
    .p0_req(p0_req), .p0_x(p0_x), .p0_y(p0_y), .p0_gnt(p0_gnt),
    .p1_req(p1_req), .p1_x(p1_x), .p1_y(p1_y), .p1_gnt(p1_gnt),
    .eng_select_valid(eng_select_valid), .eng_init_select(eng_init_select),
    .eng_cord_valid(eng_cord_valid), .eng_x(eng_x), .eng_y(eng_y),
    .eng_busy(eng_busy), .eng_hit(eng_hit), .eng_done(eng_done),
    .rsp_valid(rsp_valid), .rsp_player(rsp_player), .rsp_hit(rsp_hit),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .turn(turn), .game_over(game_over), .score0(score0), .score1(score1)
  );

  rr_pick2 u_pick (.req(u_req), .last(u_last), .strict(u_strict), .turn(u_turn),
                   .valid(u_valid), .winner(u_winner));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      n_rsp++;
      rsp_cyc = cyc;
      if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("rsp_player", 32'(rsp_player), 32'(mon_e.p));
        chk("rsp_hit", 32'(rsp_hit), 32'(mon_e.hit));
        chk("rsp_done", 32'(rsp_done), 32'(mon_e.done));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.to));
      end
    end
  end

  task automatic pick(input logic [1:0] rq, input logic l, s, t, input logic ev, ew);
    u_req = rq; u_last = l; u_strict = s; u_turn = t;
    #1;
    chk("pick_valid", 32'(u_valid), 32'(ev));
    if (ev) chk("pick_winner", 32'(u_winner), 32'(ew));
  endtask

  task automatic load_game(input logic [1:0] sel);
    @(negedge clk);
    new_game = 1; new_game_sel = sel;
    @(negedge clk);
    new_game = 0;
    chk("sel_valid", 32'(eng_select_valid), 1);
    chk("sel_value", 32'(eng_init_select), 32'(sel));
    chk("load_scores", 32'({score0, score1}), 0);
    chk("load_turn", 32'(turn), 0);
    chk("load_go", 32'(game_over), 0);
    m_turn = 0; m_go = 0; m_sc0 = 0; m_sc1 = 0;
    @(negedge clk);
    chk("sel_pulse", 32'(eng_select_valid), 0);
  endtask

  task automatic shot(input logic p, input int x, input int y, input int nbusy,
                      input logic hit, input logic done, input logic both);
    logic err, to, got;
    int g, lat;
    err = (x >= BW) || (y >= BW);
    to = !err && (nbusy >= GAP + TMO);
    sb.push_back('{p, hit && !to && !err, done && !to && !err, err, to});
    if (p) begin p1_req = 1; p1_x = 3'(x); p1_y = 3'(y); end
    else begin p0_req = 1; p0_x = 3'(x); p0_y = 3'(y); end
    if (both) begin
      if (p) begin p0_req = 1; p0_x = 0; p0_y = 0; end
      else begin p1_req = 1; p1_x = 0; p1_y = 0; end
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = p ? p1_gnt : p0_gnt;
    end
    chk("gnt_seen", 32'(got), 1);
    chk("gnt_other", 32'(p ? p0_gnt : p1_gnt), 0);
    g = cyc;
    p0_req = 0; p1_req = 0;
    if (err) begin
      chk("err_same_cycle", 32'(rsp_valid && rsp_err), 1);
      @(negedge clk);
      chk("err_no_cord", 32'(eng_cord_valid), 0);
    end else if (got) begin
      @(negedge clk);
      chk("cord_valid", 32'(eng_cord_valid), 1);
      chk("eng_xy", 32'({eng_x, eng_y}), 32'({3'(x), 3'(y)}));
      for (int i = 0; i < nbusy; i++) begin
        eng_busy = 1;
        eng_hit = hit && (i == nbusy - 1);
        eng_done = done && (i == nbusy - 1);
        @(negedge clk);
      end
      eng_busy = 0; eng_hit = 0; eng_done = 0;
    end
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("rsp_arrived", 32'(sb.size()), 0);
    sb.delete();
    if (!err) begin
      lat = to ? 4 + TMO : (nbusy <= GAP ? 5 : nbusy + 3);
      chk("rsp_latency", 32'(rsp_cyc - g), 32'(lat));
      if (to) m_turn = ~m_turn;
      else begin
        if (hit && !p) m_sc0 = (m_sc0 == 63) ? 63 : m_sc0 + 1;
        if (hit && p) m_sc1 = (m_sc1 == 63) ? 63 : m_sc1 + 1;
        if (done) m_go = 1;
        if (!hit && !done) m_turn = ~m_turn;
      end
    end
    @(negedge clk);
    chk("turn", 32'(turn), 32'(m_turn));
    chk("score0", 32'(score0), 32'(m_sc0));
    chk("score1", 32'(score1), 32'(m_sc1));
    chk("game_over", 32'(game_over), 32'(m_go));
  endtask

  initial begin
    int cnt;
    logic got;
    pick(2'b11, 1, 0, 0, 1, 0);
    pick(2'b11, 0, 0, 0, 1, 1);
    pick(2'b01, 0, 0, 1, 1, 0);
    pick(2'b10, 1, 0, 0, 1, 1);
    pick(2'b00, 0, 0, 0, 0, 0);
    pick(2'b11, 0, 1, 1, 1, 1);
    pick(2'b10, 1, 1, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst_outs", 32'({p0_gnt, p1_gnt, eng_select_valid, eng_cord_valid, rsp_valid, turn, game_over}), 0);
    chk("rst_scores", 32'({score0, score1, eng_x, eng_y}), 0);
    rst = 0;
    load_game(2);

    shot(0, 1, 2, 3, 1, 0, 0);
    shot(0, 3, 3, 0, 0, 0, 0);
    shot(1, 6, 1, 0, 0, 0, 0);
    shot(1, 0, 0, 1, 0, 0, 1);
    shot(0, 2, 4, 70, 0, 0, 0);
    shot(1, 5, 5, 2, 1, 1, 0);

    cnt = 0;
    p0_req = 1; p1_req = 1; p0_x = 1; p1_x = 1;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(p0_gnt) + int'(p1_gnt);
    end
    p0_req = 0; p1_req = 0;
    chk("gameover_no_gnt", 32'(cnt), 0);

    load_game(1);
    cnt = n_rsp;
    p0_req = 1; p0_x = 2; p0_y = 2;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = p0_gnt;
    end
    chk("abort_gnt", 32'(got), 1);
    p0_req = 0; eng_busy = 1;
    repeat (5) @(negedge clk);
    new_game = 1; new_game_sel = 3;
    @(negedge clk);
    new_game = 0; eng_busy = 0;
    chk("abort_sel_valid", 32'(eng_select_valid), 1);
    chk("abort_sel_value", 32'(eng_init_select), 3);
    repeat (10) @(negedge clk);
    chk("abort_no_rsp", 32'(n_rsp - cnt), 0);
    m_turn = 0; m_go = 0; m_sc0 = 0; m_sc1 = 0;

    for (int i = 0; i < 64; i++) shot(0, 1, 1, 1, 1, 0, 0);
    shot(0, 0, 7, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
